// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a core load-store unit and dmem_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready gates acceptance; the response side has no backpressure.
interface dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory controller: byte-addressed RAM plus LED / cycle-counter / tohost MMIO.
// Latency: response WAIT_STATES+2 cycles after acceptance (+1 for a split misaligned access).
// Backpressure: one request outstanding, req_ready only in IDLE; rsp_valid is a 1-cycle pulse.
// Optional feature: define DMEM_MISALIGN_SPLIT_EN to serve word-crossing RAM accesses in two beats.
module dmem_ctrl #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 0,
    parameter int          LED_WIDTH   = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_ctrl_if.slave           bus,
    output logic [LED_WIDTH-1:0] leds_out
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_SPLIT_EN
    // Byte-lane window spans the addressed word and the next one.
    localparam int MW = 2 * NB;
`else
    localparam int MW = NB;
`endif
    localparam logic [32:0] DEPTH33 = 33'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACCESS2, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
`endif

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [31:0]     addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t          state_q, state_d;
    logic [2:0]      wait_cnt_q;
    req_t            req_q;
    logic [XLEN-1:0] lo_q;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] hi_q;
`endif
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          cnt_q;
    logic [XLEN-1:0]      mem [DEPTH_WORDS];

    // Decode results, all derived from the latched request
    logic [1:0]      sz;
    logic            uns;
    logic [OFFW-1:0] off;
    logic [3:0]      amask;
    logic            misal;
    logic            f3_ok;
    logic [MW-1:0]   size_mask;
    logic [MW-1:0]   bmask;
    logic [MW*8-1:0] wdata_sh;
    logic [32:0]     widx;
    logic            in_ram;
    logic [AW-1:0]   idx_lo;
    logic [31:0]     mdiff;
    logic [11:0]     moff;
    logic            in_mmio;
    logic            mmio_ok;
    logic            dec_err;
    logic [XLEN-1:0] mmio_rd;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_val;
    logic [OFFW+2:0] sh;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic            cross;
    logic            in_ram2;
    logic            split;
    logic [AW-1:0]   idx_hi;
`endif

    logic accept;
    assign accept   = (state_q == S_IDLE) && bus.req_valid;
    assign leds_out = led_q;

    // Decode the latched request: byte lanes, target, fault, and load extension
    always_comb begin
        sz        = req_q.funct3[1:0];
        uns       = req_q.funct3[2];
        off       = req_q.addr[OFFW-1:0];
        amask     = (4'd1 << sz) - 4'd1;
        misal     = |(off & amask[OFFW-1:0]);
        f3_ok     = 1'b0;
        size_mask = '0;
        dec_err   = 1'b1;
        mmio_rd   = '0;
        ld_val    = '0;

        // Stores have no unsigned forms; doubleword and LWU exist only on a 64-bit datapath
        if (req_q.we)
            f3_ok = !req_q.funct3[2] && (sz != 2'd3 || XLEN == 64);
        else if (XLEN == 64)
            f3_ok = (req_q.funct3 != 3'b111);
        else
            f3_ok = (sz != 2'd3) && (req_q.funct3 != 3'b110);

        case (sz)
            2'd0:    size_mask = MW'(8'h01);
            2'd1:    size_mask = MW'(8'h03);
            2'd2:    size_mask = MW'(8'h0F);
            default: size_mask = MW'(8'hFF);
        endcase
        bmask    = size_mask << off;
        wdata_sh = (MW*8)'(req_q.wdata) << {off, 3'b000};

        widx   = {1'b0, req_q.addr} >> OFFW;
        in_ram = widx < DEPTH33;
        idx_lo = widx[AW-1:0];
`ifdef DMEM_MISALIGN_SPLIT_EN
        cross   = |bmask[MW-1:NB];
        in_ram2 = (widx + 33'd1) < DEPTH33;
        idx_hi  = idx_lo + AW'(1);
`endif

        // MMIO window is 4 KiB from MMIO_BASE and takes priority over RAM
        mdiff   = req_q.addr - MMIO_BASE;
        moff    = mdiff[11:0];
        in_mmio = mdiff < 32'h0000_1000;
        mmio_ok = (sz == 2'd2) && (mdiff[1:0] == 2'b00);

        if (!f3_ok) begin
            dec_err = 1'b1;
        end else if (in_mmio) begin
            if (!mmio_ok) begin
                dec_err = 1'b1;
            end else begin
                case (moff)
                    12'h000: dec_err = 1'b0;
                    12'h004: dec_err = 1'b0;
                    12'h008: dec_err = !req_q.we;   // tohost is write-only
                    default: dec_err = 1'b1;
                endcase
            end
        end else if (in_ram) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            dec_err = cross && !in_ram2;
`else
            dec_err = misal;
`endif
        end else begin
            dec_err = 1'b1;
        end

`ifdef DMEM_MISALIGN_SPLIT_EN
        split = !dec_err && !in_mmio && cross;
`endif

        case (moff)
            12'h000: mmio_rd = XLEN'(led_q);
            12'h004: mmio_rd = XLEN'(cnt_q);
            default: mmio_rd = '0;
        endcase

        // MMIO data is captured already right-aligned, so it is never shifted
        sh = in_mmio ? '0 : {off, 3'b000};
`ifdef DMEM_MISALIGN_SPLIT_EN
        raw = XLEN'({hi_q, lo_q} >> sh);
`else
        raw = XLEN'(lo_q >> sh);
`endif
        case (sz)
            2'd0:    ld_val = uns ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
            2'd1:    ld_val = uns ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
            2'd2:    ld_val = uns ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
            default: ld_val = raw;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.req_valid) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:    if (wait_cnt_q == 3'(WAIT_STATES - 1)) state_d = S_ACCESS;
`ifdef DMEM_MISALIGN_SPLIT_EN
            S_ACCESS:  state_d = split ? S_ACCESS2 : S_RESP;
            S_ACCESS2: state_d = S_RESP;
`else
            S_ACCESS:  state_d = S_RESP;
`endif
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs: ready in IDLE, one-cycle response in RESP, data zeroed on stores and faults
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        case (state_q)
            S_IDLE: bus.req_ready = 1'b1;
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = dec_err;
                if (!dec_err && !req_q.we) bus.rsp_rdata = ld_val;
            end
            default: ;
        endcase
    end

    // Count wait-state cycles; restarts every time the FSM is idle
    always_ff @(posedge clk) begin
        if (!rst)                   wait_cnt_q <= '0;
        else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 3'd1;
        else                        wait_cnt_q <= '0;
    end

    // Capture the request on acceptance so later bus changes cannot disturb it
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.we     <= bus.req_we;
            req_q.funct3 <= bus.req_funct3;
            req_q.addr   <= bus.req_addr;
            req_q.wdata  <= bus.req_wdata;
        end
    end

    // Capture read data: low word (or MMIO value) in ACCESS, next word in ACCESS2
    always_ff @(posedge clk) begin
        if (!rst) begin
            lo_q <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            hi_q <= '0;
`endif
        end else begin
            if (state_q == S_ACCESS) lo_q <= in_mmio ? mmio_rd : mem[idx_lo];
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (state_q == S_ACCESS2) hi_q <= mem[idx_hi];
`endif
        end
    end

    // RAM byte-lane writes; faulted stores and MMIO stores never touch the array
    always_ff @(posedge clk) begin
        if (rst && req_q.we && !dec_err && !in_mmio) begin
            if (state_q == S_ACCESS) begin
                for (int b = 0; b < NB; b++)
                    if (bmask[b]) mem[idx_lo][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (state_q == S_ACCESS2) begin
                for (int b = 0; b < NB; b++)
                    if (bmask[NB+b]) mem[idx_hi][8*b +: 8] <= wdata_sh[8*(NB+b) +: 8];
            end
`endif
        end
    end

    // LED register write and free-running cycle counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (state_q == S_ACCESS && req_q.we && !dec_err && in_mmio && moff == 12'h000)
                led_q <= req_q.wdata[LED_WIDTH-1:0];
        end
    end

`ifndef SYNTHESIS
    // tohost: writing bit0=1 ends a simulation run
    always_ff @(posedge clk) begin
        if (rst && state_q == S_ACCESS && req_q.we && !dec_err && in_mmio &&
            moff == 12'h008 && req_q.wdata[0]) begin
            $display("PASS: tohost write, ending simulation");
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (XLEN=32, 256 words, 2 wait states).
// Latency: measured per transaction from acceptance to rsp_valid.
// Backpressure: waits on req_ready before each request.
module tb_dmem_ctrl;
    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [31:0] MB    = 32'h8000_0000;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] leds;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.XLEN(32)) bus ();

    dmem_ctrl #(
        .XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .LED_WIDTH(4), .MMIO_BASE(MB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .leds_out(leds)
    );

    int total = 0;
    int bad   = 0;
    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    logic [31:0] r_dat;
    logic        r_err;
    int          r_lat;
    int          acc_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge, scramble the bus after acceptance, collect the response
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdat);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdat;
        @(posedge clk);
        #1;
        acc_cyc        = tb_cyc;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = f3 ^ 3'b010;
        bus.req_addr   = addr ^ 32'h0000_0FF0;
        bus.req_wdata  = ~wdat;
        r_lat = 0;
        r_dat = 32'hXXXX_XXXX;
        r_err = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                r_lat = i;
                r_dat = bus.rsp_rdata;
                r_err = bus.rsp_err;
                break;
            end
        end
        if (r_lat == 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [31:0] exp_dat, input logic exp_err, input int exp_lat);
        xfer(we, f3, addr, wdat);
        chk({tag, "_dat"}, r_dat, exp_dat);
        chk({tag, "_err"}, 32'(r_err), 32'(exp_err));
        chk({tag, "_lat"}, r_lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c1, c2, w100;
        int a1, seen;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // RAM word, byte and halfword accesses
        run("sw100",  1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0,         1'b0, 4);
        run("lw100",  1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD_BEEF, 1'b0, 4);
        run("sb103",  1'b1, 3'd0, 32'h103, 32'h0000_0080, 32'h0,        1'b0, 4);
        run("lb103",  1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFF_FF80, 1'b0, 4);
        run("lbu103", 1'b0, 3'd4, 32'h103, 32'h0,        32'h0000_0080, 1'b0, 4);
        run("lw100b", 1'b0, 3'd2, 32'h100, 32'h0,        32'h80AD_BEEF, 1'b0, 4);
        run("lh102",  1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFF_80AD, 1'b0, 4);
        run("lhu100", 1'b0, 3'd5, 32'h100, 32'h0,        32'h0000_BEEF, 1'b0, 4);
        run("sh100",  1'b1, 3'd1, 32'h100, 32'hFFFF_1234, 32'h0,        1'b0, 4);
        run("lw100c", 1'b0, 3'd2, 32'h100, 32'h0,        32'h80AD_1234, 1'b0, 4);

        // MMIO: LEDs, width fault, tohost, unmapped, cycle counter
        run("sw_led", 1'b1, 3'd2, MB, 32'h0000_0005, 32'h0, 1'b0, 4);
        chk("leds_5", 32'(leds), 32'h5);
        run("sb_led", 1'b1, 3'd0, MB, 32'h0000_000F, 32'h0, 1'b1, 4);
        chk("leds_kept", 32'(leds), 32'h5);
        run("lw_led", 1'b0, 3'd2, MB, 32'h0, 32'h0000_0005, 1'b0, 4);
        run("tohost", 1'b1, 3'd2, MB + 32'h8, 32'h0000_0000, 32'h0, 1'b0, 4);
        run("mmio_c", 1'b0, 3'd2, MB + 32'hC, 32'h0, 32'h0, 1'b1, 4);
        xfer(1'b0, 3'd2, MB + 32'h4, 32'h0);
        c1 = r_dat;
        a1 = acc_cyc;
        while (tb_cyc < a1 + 9) @(negedge clk);
        xfer(1'b0, 3'd2, MB + 32'h4, 32'h0);
        c2 = r_dat;
        chk("cnt_err", 32'(r_err), 32'd0);
        chk("cnt_delta", c2 - c1, 32'd10);

        // RAM range boundary
        run("sw0",    1'b1, 3'd2, 32'h000, 32'h0BAD_F00D, 32'h0, 1'b0, 4);
        run("sw3fc",  1'b1, 3'd2, 32'h3FC, 32'h0000_0077, 32'h0, 1'b0, 4);
        run("lw3fc",  1'b0, 3'd2, 32'h3FC, 32'h0, 32'h0000_0077, 1'b0, 4);
        run("lw400",  1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 4);
        run("sw400",  1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b1, 4);
        run("lw0",    1'b0, 3'd2, 32'h000, 32'h0, 32'h0BAD_F00D, 1'b0, 4);

        // Misaligned accesses
        run("sw104",  1'b1, 3'd2, 32'h104, 32'hA5A5_A5A5, 32'h0, 1'b0, 4);
        run("sw102",  1'b1, 3'd2, 32'h102, 32'h1122_3344, 32'h0, !SPLIT, SPLIT ? 5 : 4);
        run("lw102",  1'b0, 3'd2, 32'h102, 32'h0, SPLIT ? 32'h1122_3344 : 32'h0, !SPLIT,
            SPLIT ? 5 : 4);
        run("lw100d", 1'b0, 3'd2, 32'h100, 32'h0, SPLIT ? 32'h3344_1234 : 32'h80AD_1234,
            1'b0, 4);
        run("lw104",  1'b0, 3'd2, 32'h104, 32'h0, SPLIT ? 32'hA5A5_1122 : 32'hA5A5_A5A5,
            1'b0, 4);
        run("lh101",  1'b0, 3'd1, 32'h101, 32'h0, SPLIT ? 32'h0000_4412 : 32'h0, !SPLIT, 4);
        run("sw3fe",  1'b1, 3'd2, 32'h3FE, 32'hDEAD_DEAD, 32'h0, 1'b1, 4);
        run("lw3fe",  1'b0, 3'd2, 32'h3FE, 32'h0, 32'h0, 1'b1, 4);
        run("lw3fcb", 1'b0, 3'd2, 32'h3FC, 32'h0, 32'h0000_0077, 1'b0, 4);

        // Reset during WAIT of a pending store
        w100 = SPLIT ? 32'h3344_1234 : 32'h80AD_1234;
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h100;
        bus.req_wdata  = 32'h9999_9999;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("rst_mid_no_rsp", seen, 0);
        chk("rst_mid_leds", 32'(leds), 32'd0);
        run("lw100_rst", 1'b0, 3'd2, 32'h100, 32'h0, w100, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, RAM depth in XLEN-bit words; power of two.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra RAM access cycles; range 0-7.
REQ-004 SHALL have parameter LED_WIDTH, default 4, LED register width; range 1 to XLEN.
REQ-005 SHALL have parameter MMIO_BASE, default 32'h80000000, base address of the MMIO window.
REQ-006 SHALL have port clk  in  1  system clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-008 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-009 SHALL have ports req_we in 1 (store), req_funct3 in 3 (LB/LH/LW/LBU/LHU/SB/SH/SW; LD/LWU/SD when XLEN=64), req_addr in 32 (byte address), req_wdata in XLEN.
REQ-010 SHALL have ports rsp_valid out 1, rsp_rdata out XLEN (extended load data), rsp_err out 1 (access fault).
REQ-011 SHALL have port leds_out  out  LED_WIDTH  LED register contents.

Function
REQ-012 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; req_ready=1 only in IDLE, so at most one request is outstanding.
REQ-013 SHALL implement FSM IDLE -> WAIT (held WAIT_STATES cycles; skipped when 0) -> ACCESS -> [ACCESS2] -> RESP -> IDLE.
REQ-014 SHALL latch req_* on acceptance; later changes on req_* SHALL NOT affect the accepted request.
REQ-015 SHALL assert rsp_valid for exactly one cycle in RESP, for loads and for stores, with no backpressure.
REQ-016 SHALL place RESP at WAIT_STATES+2 cycles after acceptance, plus 1 cycle when ACCESS2 is used.
REQ-017 SHALL derive byte lanes from funct3 and address offset; stores SHALL write only the addressed bytes.
REQ-018 SHALL sign-extend LB/LH/LW(XLEN=64) and zero-extend LBU/LHU/LWU into rsp_rdata.
REQ-019 SHALL drive rsp_rdata=0 for stores and for every response with rsp_err=1.
REQ-020 SHALL decode RAM as word index (req_addr/(XLEN/8)) < DEPTH_WORDS; RAM-range accesses SHALL wrap nowhere; out-of-range accesses SHALL give rsp_err=1 and perform no write.
REQ-021 SHALL decode MMIO_BASE+0 as LED register (read/write, low LED_WIDTH bits) and MMIO_BASE+4 as a free-running 32-bit cycle counter (read-only; writes ignored, rsp_err=0).
REQ-022 SHALL treat an MMIO access that is not full-word width and aligned as rsp_err=1, with no side effect; other MMIO_BASE-window addresses SHALL give rsp_err=1.
REQ-023 SHALL return rsp_err=0 for a store to MMIO_BASE+8 (tohost); in simulation builds, bit0=1 SHALL print a PASS message and end the simulation.
REQ-024 SHALL update the cycle counter every cycle, including during WAIT, and wrap from 2^32-1 to 0.
REQ-025 SHALL make read-after-write consistent: a load accepted after a store's RESP SHALL return the stored data.

Reset
REQ-026 SHALL, when rst=0 at a rising edge, force state IDLE, req_ready=1 from the next cycle, rsp_valid=0, rsp_err=0, rsp_rdata=0, LED register 0, and cycle counter 0.
REQ-027 SHALL abandon a request caught mid-operation by reset with no response; a store SHALL not write if reset arrives before ACCESS, and RAM contents are not cleared.

Configuration
REQ-028 SHALL use macro DMEM_MISALIGN_SPLIT_EN.
REQ-029 With DMEM_MISALIGN_SPLIT_EN defined, a misaligned RAM access crossing a word boundary SHALL use ACCESS (low word) then ACCESS2 (next word), merge the bytes, and return rsp_err=0; a second word out of range SHALL give rsp_err=1 with neither word written.
REQ-030 Without DMEM_MISALIGN_SPLIT_EN, any misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; XLEN=64 doubleword with addr[2:0]!=0) SHALL give rsp_err=1 with no write, and ACCESS2 SHALL not exist.
REQ-031 A misaligned access that stays within one word (for example LH at offset 1, XLEN=32) SHALL complete in one ACCESS when DMEM_MISALIGN_SPLIT_EN is defined.

Verification
REQ-032 WAIT_STATES=2: SW 0xDEADBEEF to 0x100, then LW 0x100 -> each rsp_valid 4 cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-033 SB 0x80 to 0x103, then LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LW 0x100 -> 0x80ADBEEF.
REQ-034 SW 0x5 to MMIO_BASE -> leds_out=0x5; SB to MMIO_BASE -> err=1, leds unchanged; two LWs of MMIO_BASE+4 issued 10 cycles apart -> values differ by 10.
REQ-035 LW at address DEPTH_WORDS*4 -> err=1, rdata=0; a following SW there -> err=1, RAM unchanged.
REQ-036 SW 0x11223344 to 0x102 -> with macro: rsp at WAIT_STATES+3 cycles, err=0, and LW 0x102 returns 0x11223344; without macro: err=1, no write.
REQ-037 Drive rst=0 during WAIT of a pending SW -> no rsp_valid, target word unchanged, req_ready=1 the cycle after rst returns to 1.
